// File: rtl/bram_rd_pkg.sv
// Shared types and helpers for the BRAM simple-dual-port read streamer:
// FSM state encoding, skid FIFO sizing and the per-byte parity check.
package bram_rd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int FIFO_DEPTH = 2;
    localparam int FIFO_CNT_W = 2;

    // Widest word the parity helper accepts: 8 data bytes plus 8 parity bits.
    localparam int PAR_MAX_BYTES = 8;
    localparam int PAR_MAX_W     = 9 * PAR_MAX_BYTES;

    // Returns 1 when any of the first nb bytes fails even parity. Byte k is
    // word[8k+7:8k] and its parity bit sits at word[8*nb+k].
    function automatic logic parity_err(input logic [PAR_MAX_W-1:0] word, input int nb);
        logic       err;
        logic [6:0] par_idx;
        logic [6:0] byte_lsb;
        err = 1'b0;
        for (int k = 0; k < PAR_MAX_BYTES; k++) begin
            if (k < nb) begin
                byte_lsb = 7'(8 * k);
                par_idx  = 7'(8 * nb + k);
                err      = err | (^{word[byte_lsb +: 8], word[par_idx]});
            end
        end
        return err;
    endfunction

endpackage

// File: rtl/bram_rd_skid_fifo.sv
// Two-entry register FIFO that holds BRAM read words (data + last flag)
// while the downstream stream applies backpressure.
module bram_rd_skid_fifo
    import bram_rd_pkg::*;
#(
    parameter int WIDTH = 37
) (
    input  logic                  CLK_i,
    input  logic                  RST_i,
    input  logic                  PUSH_i,
    input  logic [WIDTH-1:0]      PUSH_DATA_i,
    input  logic                  POP_i,
    output logic [WIDTH-1:0]      HEAD_o,
    output logic [FIFO_CNT_W-1:0] COUNT_o
);

    logic [WIDTH-1:0]      r_mem [FIFO_DEPTH];
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [FIFO_CNT_W-1:0] r_count;

    // Single-bit pointers: the depth is fixed at two, so they simply toggle.
    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            // NOTE: the storage is reset on purpose so the stream data output
            // reads zero straight out of reset, not leftover words.
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= '0;
        end else begin
            if (PUSH_i) begin
                r_mem[r_wr_ptr] <= PUSH_DATA_i;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (POP_i) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({PUSH_i, POP_i})
                2'b10:   r_count <= r_count + FIFO_CNT_W'(1);
                2'b01:   r_count <= r_count - FIFO_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign HEAD_o  = r_mem[r_rd_ptr];
    assign COUNT_o = r_count;

endmodule

// File: rtl/bram_sdp_rd_streamer.sv
// Burst read engine for a simple-dual-port block RAM: issues REN/RD_ADDR,
// captures RDATA one cycle later and streams it out on valid/ready.
// Optional per-byte even-parity checker enabled by `define BRAM_RD_PARITY_EN.
module bram_sdp_rd_streamer
    import bram_rd_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 36
) (
    input  logic                  CLK_i,
    input  logic                  RST_i,
    input  logic                  START_i,
    input  logic [ADDR_WIDTH-1:0] BASE_ADDR_i,
    input  logic [ADDR_WIDTH:0]   LEN_i,
    output logic                  BUSY_o,
    output logic                  DONE_o,
    output logic                  REN_o,
    output logic [ADDR_WIDTH-1:0] RD_ADDR_o,
    input  logic [DATA_WIDTH-1:0] RDATA_i,
    output logic [DATA_WIDTH-1:0] DATA_o,
    output logic                  VALID_o,
    input  logic                  READY_i,
    output logic                  LAST_o
`ifdef BRAM_RD_PARITY_EN
    ,
    output logic                  PERR_o
`endif
);

    localparam int LEN_W = ADDR_WIDTH + 1;
    localparam int OCC_W = FIFO_CNT_W + 1;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [LEN_W-1:0]      r_remaining;
    logic                  r_inflight;
    logic                  r_inflight_last;

    logic [DATA_WIDTH:0]   w_head;
    logic [FIFO_CNT_W-1:0] w_count;
    logic [OCC_W-1:0]      w_occupancy;
    logic                  w_valid;
    logic                  w_pop;
    logic                  w_credit;
    logic                  w_ren;
    logic                  w_last_issue;
    logic                  w_start_ok;
    logic                  w_done;

    assign w_valid     = (w_count != '0);
    assign w_pop       = w_valid & READY_i;
    assign w_done      = w_pop & w_head[DATA_WIDTH];
    assign w_start_ok  = (r_state == IDLE) && START_i && (LEN_i != '0);

    // Words already committed (in the FIFO or in the BRAM pipeline) minus the
    // one leaving this cycle must leave room for the read issued now.
    assign w_occupancy = {1'b0, w_count} + OCC_W'(r_inflight);
    assign w_credit    = w_occupancy < (OCC_W'(FIFO_DEPTH) + OCC_W'(w_pop));

    assign w_last_issue = w_ren && (r_remaining == LEN_W'(1));

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case can leave one unassigned and infer a latch.
        w_state_nxt = r_state;
        w_ren       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start_ok) begin
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                w_ren = w_credit;
                if (w_credit && (r_remaining == LEN_W'(1))) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (w_done) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            r_addr          <= '0;
            r_remaining     <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            r_inflight      <= w_ren;
            r_inflight_last <= w_last_issue;
            if (w_start_ok) begin
                r_addr      <= BASE_ADDR_i;
                r_remaining <= LEN_i;
            end else if (w_ren) begin
                r_addr      <= r_addr + ADDR_WIDTH'(1);
                r_remaining <= r_remaining - LEN_W'(1);
            end
        end
    end

    bram_rd_skid_fifo #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_fifo (
        .CLK_i       (CLK_i),
        .RST_i       (RST_i),
        .PUSH_i      (r_inflight),
        .PUSH_DATA_i ({r_inflight_last, RDATA_i}),
        .POP_i       (w_pop),
        .HEAD_o      (w_head),
        .COUNT_o     (w_count)
    );

    assign BUSY_o    = (r_state != IDLE);
    assign DONE_o    = w_done;
    assign REN_o     = w_ren;
    assign RD_ADDR_o = r_addr;
    assign DATA_o    = w_head[DATA_WIDTH-1:0];
    assign VALID_o   = w_valid;
    assign LAST_o    = w_valid & w_head[DATA_WIDTH];

`ifdef BRAM_RD_PARITY_EN
    localparam int NB = DATA_WIDTH / 9;

    logic                 r_perr;
    logic [PAR_MAX_W-1:0] w_par_word;

    assign w_par_word = PAR_MAX_W'(w_head[DATA_WIDTH-1:0]);

    // Sticky until the next accepted burst; only words actually handed
    // downstream are checked.
    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            r_perr <= 1'b0;
        end else if (w_start_ok) begin
            r_perr <= 1'b0;
        end else if (w_pop && parity_err(w_par_word, NB)) begin
            r_perr <= 1'b1;
        end
    end

    assign PERR_o = r_perr;
`endif

endmodule

// File: tb/tb_bram_sdp_rd_streamer.sv
// Self-checking bench for bram_sdp_rd_streamer: behavioural BRAM and burst
// model compared every cycle, plus directed literal checks and random bursts.
`timescale 1ns/1ps
module tb_bram_sdp_rd_streamer;

    localparam int AW    = 10;
    localparam int DW    = 36;
    localparam int DEPTH = 1 << AW;

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic          start = 1'b0;
    logic          ready = 1'b1;
    logic [AW-1:0] base  = '0;
    logic [AW:0]   len   = '0;
    logic [DW-1:0] rdata = '0;

    logic          busy_o, done_o, ren_o, valid_o, last_o;
    logic [AW-1:0] rd_addr_o;
    logic [DW-1:0] data_o;
`ifdef BRAM_RD_PARITY_EN
    logic          perr_o;
`endif

    bram_sdp_rd_streamer #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .CLK_i       (clk),
        .RST_i       (rst),
        .START_i     (start),
        .BASE_ADDR_i (base),
        .LEN_i       (len),
        .BUSY_o      (busy_o),
        .DONE_o      (done_o),
        .REN_o       (ren_o),
        .RD_ADDR_o   (rd_addr_o),
        .RDATA_i     (rdata),
        .DATA_o      (data_o),
        .VALID_o     (valid_o),
        .READY_i     (ready),
        .LAST_o      (last_o)
`ifdef BRAM_RD_PARITY_EN
        ,
        .PERR_o      (perr_o)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural BRAM: registered read, data appears the cycle after REN.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) if (ren_o) rdata <= mem[rd_addr_o];

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit par_bad(input logic [DW-1:0] w);
        bit e = 1'b0;
        for (int k = 0; k < 4; k++) e = e | (^{w[8*k +: 8], w[32+k]});
        return e;
    endfunction

    // ---------------- burst model ----------------
    bit            m_busy   = 1'b0;
    int            m_len    = 0;
    int            m_issued = 0;
    int            m_popped = 0;
    logic [AW-1:0] m_base   = '0;
    bit            m_perr   = 1'b0;
    int            t_issue [DEPTH+1];
    logic          rst_q    = 1'b0;

    always @(posedge clk) rst_q <= rst;

    always @(negedge clk) begin : compare
        bit            exp_ren, exp_valid, exp_last, pop, was_busy;
        int            outst;
        logic [AW-1:0] a;
        if (rst_q) begin
            check("rst_busy",  64'(busy_o),    64'(0));
            check("rst_done",  64'(done_o),    64'(0));
            check("rst_ren",   64'(ren_o),     64'(0));
            check("rst_addr",  64'(rd_addr_o), 64'(0));
            check("rst_data",  64'(data_o),    64'(0));
            check("rst_valid", 64'(valid_o),   64'(0));
            check("rst_last",  64'(last_o),    64'(0));
`ifdef BRAM_RD_PARITY_EN
            check("rst_perr",  64'(perr_o),    64'(0));
`endif
        end
        if (rst) begin
            m_busy   = 1'b0;
            m_issued = 0;
            m_popped = 0;
            m_perr   = 1'b0;
        end else begin
            was_busy  = m_busy;
            outst     = m_issued - m_popped;
            exp_valid = m_busy && (m_popped < m_issued) && (cyc >= t_issue[m_popped] + 2);
            exp_last  = exp_valid && (m_popped == m_len - 1);
            pop       = exp_valid && ready;
            exp_ren   = m_busy && (m_issued < m_len) && ((outst - int'(pop)) < 2);
            check("busy",  64'(busy_o),  64'(m_busy));
            check("ren",   64'(ren_o),   64'(exp_ren));
            check("valid", 64'(valid_o), 64'(exp_valid));
            check("done",  64'(done_o),  64'(pop && exp_last));
            if (exp_ren) check("rd_addr", 64'(rd_addr_o), 64'(AW'(m_base + m_issued)));
            a = AW'(m_base + m_popped);
            if (exp_valid) begin
                check("data", 64'(data_o), 64'(mem[a]));
                check("last", 64'(last_o), 64'(exp_last));
            end
`ifdef BRAM_RD_PARITY_EN
            check("perr", 64'(perr_o), 64'(m_perr));
            if (pop && par_bad(mem[a])) m_perr = 1'b1;
`endif
            if (exp_ren) begin
                t_issue[m_issued] = cyc;
                m_issued++;
            end
            if (pop) begin
                m_popped++;
                if (m_popped == m_len) m_busy = 1'b0;
            end
            if (start && !was_busy && (len != '0)) begin
                m_busy   = 1'b1;
                m_base   = base;
                m_len    = int'(len);
                m_issued = 0;
                m_popped = 0;
                m_perr   = 1'b0;
            end
        end
        cyc++;
    end

    // ---------------- stimulus helpers ----------------
    int ready_mode = 0;  // 0 always, 1 toggle, 2 mostly ready, 3 coin flip

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       ready = 1'b1;
                1:       ready = ~ready;
                2:       ready = ($urandom_range(0, 3) != 0);
                default: ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic do_start(input logic [AW-1:0] b, input int l);
        @(posedge clk);
        #1;
        start = 1'b1;
        base  = b;
        len   = (AW+1)'(l);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((m_busy || busy_o) && (n < budget)) begin
            @(posedge clk);
            n++;
        end
        n_checks++;
        if (n >= budget) begin
            n_errors++;
            $display("FAIL idle_timeout: still busy after %0d cycles, required idle", n);
        end
        repeat (2) @(posedge clk);
    endtask

    initial begin
        #5ms;
        n_errors++;
        $display("FAIL global_timeout: simulation did not complete, required completion");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [7:0]    ren_m, val_m, done_m, last_m;
        logic [DW-1:0] data6;
        logic [AW-1:0] addrs [3];
        int            na, beats, dones, rens;

        for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);

        // LEN=4 at 0x010, ready held high: pin exact cycle positions.
        ready_mode = 0;
        do_start(10'h010, 4);
        ren_m = '0; val_m = '0; done_m = '0; last_m = '0; data6 = '0;
        for (int o = 1; o <= 8; o++) begin
            @(negedge clk);
            ren_m[o-1]  = ren_o;
            val_m[o-1]  = valid_o;
            done_m[o-1] = done_o;
            last_m[o-1] = last_o;
            if (o == 6) data6 = data_o;
        end
        check("t1_ren_cycles",   64'(ren_m),  64'h0F);
        check("t1_valid_cycles", 64'(val_m),  64'h3C);
        check("t1_done_cycle",   64'(done_m), 64'h20);
        check("t1_last_cycle",   64'(last_m), 64'h20);
        check("t1_last_data",    64'(data6),  64'h13);
        wait_idle(100);

        // Address wrap from 0x3FE.
        do_start(10'h3FE, 3);
        na = 0;
        for (int o = 0; o < 8; o++) begin
            @(negedge clk);
            if (ren_o && na < 3) begin
                addrs[na] = rd_addr_o;
                na++;
            end
        end
        check("t2_issues", 64'(na),       64'(3));
        check("t2_addr0",  64'(addrs[0]), 64'h3FE);
        check("t2_addr1",  64'(addrs[1]), 64'h3FF);
        check("t2_addr2",  64'(addrs[2]), 64'h000);
        wait_idle(100);

        // LEN=8 with ready toggling: backpressure and credit stalls.
        ready_mode = 1;
        do_start(10'h123, 8);
        beats = 0; dones = 0; rens = 0;
        for (int o = 0; o < 60; o++) begin
            @(negedge clk);
            if (valid_o && ready) beats++;
            if (done_o) dones++;
            if (ren_o) rens++;
        end
        check("t3_beats", 64'(beats), 64'(8));
        check("t3_dones", 64'(dones), 64'(1));
        check("t3_rens",  64'(rens),  64'(8));
        wait_idle(100);

        // Reset two cycles into a LEN=16 burst, then a clean burst.
        ready_mode = 0;
        do_start(10'h040, 16);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("t4_busy_after_rst",  64'(busy_o),  64'(0));
        check("t4_valid_after_rst", 64'(valid_o), 64'(0));
        @(negedge clk);
        check("t4_no_stale_capture", 64'(valid_o), 64'(0));
        do_start(10'h080, 5);
        wait_idle(100);

        // LEN=0 no-op, then START while busy is ignored.
        do_start(10'h055, 0);
        rens = 0;
        for (int o = 0; o < 5; o++) begin
            @(negedge clk);
            if (ren_o || busy_o) rens++;
        end
        check("t5_len0_noop", 64'(rens), 64'(0));
        do_start(10'h100, 6);
        rens = 0; dones = 0;
        for (int o = 0; o < 30; o++) begin
            @(negedge clk);
            if (ren_o) rens++;
            if (done_o) dones++;
            @(posedge clk);
            #1;
            if (o == 0) begin
                start = 1'b1;
                base  = 10'h200;
                len   = 11'd9;
            end else if (o == 1) begin
                start = 1'b0;
            end
        end
        check("t5_busy_start_rens",  64'(rens),  64'(6));
        check("t5_busy_start_dones", 64'(dones), 64'(1));
        wait_idle(100);

`ifdef BRAM_RD_PARITY_EN
        // Good parity everywhere, then one word with bit 35 flipped.
        for (int i = 0; i < DEPTH; i++) begin
            mem[i][31:0] = $urandom;
            for (int k = 0; k < 4; k++) mem[i][32+k] = ^mem[i][8*k +: 8];
        end
        mem[10'h022][35] = ~mem[10'h022][35];
        do_start(10'h020, 4);
        wait_idle(100);
        check("t7_perr_set", 64'(perr_o), 64'(1));
        do_start(10'h030, 2);
        @(negedge clk);
        check("t7_perr_clear", 64'(perr_o), 64'(0));
        wait_idle(100);
`endif

        // Random bursts against the model.
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'({$urandom, $urandom});
        for (int b = 0; b < 25; b++) begin
            ready_mode = $urandom_range(0, 3);
            do_start(AW'($urandom), $urandom_range(1, 40));
            wait_idle(1000);
        end
        ready_mode = 0;
        do_start(AW'($urandom), DEPTH);
        wait_idle(3000);
        ready_mode = 2;
        do_start(AW'($urandom), DEPTH);
        wait_idle(5000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
